// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared pipeline types and widths
package core_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } mem_err_t;
endpackage

// File: rtl/dmem_if_fsm.sv
// rtl/dmem_if_fsm.sv - single-outstanding data-memory handshake with timeout abort
module dmem_if_fsm
    import core_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid,
    input  logic ready,
    output logic stall,
    output logic xfer,
    output logic abort
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             last;

    assign last = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A late ready in the last allowed cycle wins over the abort.
    always_comb begin
        state_next = IDLE;
        cnt_next   = '0;
        xfer       = valid && ready;
        abort      = valid && !ready && last;
        stall      = valid && !ready && !last;
        case (state)
            IDLE: begin
                if (stall) begin
                    state_next = WAIT;
                    cnt_next   = CNT_ONE;
                end
            end
            WAIT: begin
                if (stall) begin
                    state_next = WAIT;
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX/MEM and MEM/WB registers around the data-memory bus
module mem_stage
    import core_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] aluoutE,
    input  logic [DATA_W-1:0] writedataE,
    input  logic [4:0]        writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              memwriteE,
    output logic [ADDR_W-1:0] aluoutM,
    output logic [4:0]        writeregM,
    output logic              regwriteM,
    output logic              stallM,
    output logic              dmem_valid,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [ADDR_W-1:0] aluoutW,
    output logic [DATA_W-1:0] readdataW,
    output logic [4:0]        writeregW,
    output logic              regwriteW,
    output logic              memtoregW,
    output logic [DATA_W-1:0] resultW,
    output logic [1:0]        errcodeM
);
    logic [DATA_W-1:0] writedataM;
    logic              memtoregM, memwriteM;
    logic              memopM, misalignM, xferM, abortM;
    mem_err_t          err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluoutM    <= '0;
            writedataM <= '0;
            writeregM  <= '0;
            regwriteM  <= 1'b0;
            memtoregM  <= 1'b0;
            memwriteM  <= 1'b0;
        end else if (!stallM) begin
            aluoutM    <= aluoutE;
            writedataM <= writedataE;
            writeregM  <= writeregE;
            regwriteM  <= regwriteE;
            memtoregM  <= memtoregE;
            memwriteM  <= memwriteE;
        end
    end

    // Misaligned word accesses never reach the bus; they retire as bubbles.
    assign memopM     = memtoregM | memwriteM;
    assign misalignM  = memopM && (aluoutM[1:0] != 2'b00);
    assign dmem_valid = memopM && !misalignM;
    assign dmem_we    = dmem_valid && memwriteM;
    assign dmem_addr  = aluoutM;
    assign dmem_wdata = writedataM;

    dmem_if_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (dmem_valid),
        .ready (dmem_ready),
        .stall (stallM),
        .xfer  (xferM),
        .abort (abortM)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluoutW   <= '0;
            readdataW <= '0;
            writeregW <= '0;
            regwriteW <= 1'b0;
            memtoregW <= 1'b0;
        end else if (stallM) begin
            regwriteW <= 1'b0;
        end else begin
            aluoutW   <= aluoutM;
            writeregW <= writeregM;
            memtoregW <= memtoregM;
            regwriteW <= regwriteM && !misalignM && !abortM;
            if (xferM && memtoregM) begin
                readdataW <= dmem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= ERR_NONE;
        end else if (err_q == ERR_NONE && !stallM) begin
            if (misalignM) begin
                err_q <= ERR_MISALIGN;
            end else if (abortM) begin
                err_q <= ERR_TIMEOUT;
            end
        end
    end

    assign errcodeM = err_q;
    assign resultW  = memtoregW ? readdataW : aluoutW;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;
    localparam int T = 8;

    logic        clk, rst_n;
    logic [31:0] aluoutE, writedataE;
    logic [4:0]  writeregE;
    logic        regwriteE, memtoregE, memwriteE;
    logic [31:0] aluoutM;
    logic [4:0]  writeregM;
    logic        regwriteM, stallM;
    logic        dmem_valid, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] aluoutW, readdataW, resultW;
    logic [4:0]  writeregW;
    logic        regwriteW, memtoregW;
    logic [1:0]  errcodeM;

    int tests = 0;
    int fails = 0;

    logic [31:0] dev_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [1:0]  err_m;
    logic [31:0] rd_m;

    mem_stage #(.TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .aluoutE(aluoutE), .writedataE(writedataE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .memwriteE(memwriteE),
        .aluoutM(aluoutM), .writeregM(writeregM), .regwriteM(regwriteM),
        .stallM(stallM),
        .dmem_valid(dmem_valid), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .aluoutW(aluoutW), .readdataW(readdataW), .writeregW(writeregW),
        .regwriteW(regwriteW), .memtoregW(memtoregW), .resultW(resultW),
        .errcodeM(errcodeM)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic [31:0] a, wd, rdata;
        logic [4:0]  wr;
        logic        rw, mt, mw;
        int          waits;
        int          exp_stalls, exp_valids;
        logic [31:0] exp_result;
        logic        exp_rw;
        logic [1:0]  exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        if (dev_mem.exists(a)) return dev_mem[a];
        return mem_default(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return mem_default(a);
    endfunction

    task automatic set_e(input logic [31:0] a, wd, input logic [4:0] wr,
                         input logic rw, mt, mw);
        aluoutE = a; writedataE = wd; writeregE = wr;
        regwriteE = rw; memtoregE = mt; memwriteE = mw;
    endtask

    task automatic do_reset();
        dmem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        err_m = 2'b00;
        rd_m = 32'h0;
    endtask

    // Issues one op into M, plays the memory device, returns once the op has left M.
    task automatic issue(input logic [31:0] a, wd, input logic [4:0] wr,
                         input logic rw, mt, mw, input int waits,
                         output int stalls, output int valids);
        int  n;
        bit  done;
        logic s;
        set_e(a, wd, wr, rw, mt, mw);
        @(posedge clk); #1;
        set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        stalls = 0; valids = 0; n = 0; done = 0;
        while (!done && n < 40) begin
            #1;
            dmem_ready = (n >= waits);
            dmem_rdata = dev_rd(dmem_addr);
            #1;
            if (dmem_valid) begin
                valids++;
                chk("bus_addr", dmem_addr, a);
                chk("bus_we", 32'(dmem_we), 32'(mw));
                chk("bus_wdata", dmem_wdata, wd);
            end
            s = stallM;
            if (s) stalls++;
            if (dmem_valid && dmem_ready && dmem_we) dev_mem[dmem_addr] = dmem_wdata;
            @(posedge clk); #1;
            if (s) chk("bubble_regwriteW", 32'(regwriteW), 32'h0);
            else done = 1;
            n++;
        end
        if (!done) chk("op_leaves_M", 32'h0, 32'h1);
        dmem_ready = 1'b0;
    endtask

    vec_t tbl[11];

    initial begin
        int st, va;
        rst_n = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        err_m = 2'b00;
        rd_m = 32'h0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_aluoutM", aluoutM, 32'h0);
        chk("rst_writeregM", 32'(writeregM), 32'h0);
        chk("rst_regwriteM", 32'(regwriteM), 32'h0);
        chk("rst_stallM", 32'(stallM), 32'h0);
        chk("rst_dmem_valid", 32'(dmem_valid), 32'h0);
        chk("rst_resultW", resultW, 32'h0);
        chk("rst_regwriteW", 32'(regwriteW), 32'h0);
        chk("rst_errcodeM", 32'(errcodeM), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        //        rst  a             wd            rdata         wr     rw mt mw waits stl val result        rw err
        tbl[0]  = '{1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 5'd5,  1, 1, 0, 0,   0, 1, 32'hDEADBEEF, 1, 2'b00};
        tbl[1]  = '{1'b0, 32'h200, 32'h12345678, 32'h0,        5'd0,  0, 0, 1, 3,   3, 4, 32'h200,      0, 2'b00};
        tbl[2]  = '{1'b0, 32'h55,  32'h0,        32'h0,        5'd7,  1, 0, 0, 0,   0, 0, 32'h55,       1, 2'b00};
        tbl[3]  = '{1'b0, 32'h104, 32'h0,        32'hCAFEF00D, 5'd9,  1, 1, 0, 5,   5, 6, 32'hCAFEF00D, 1, 2'b00};
        tbl[4]  = '{1'b0, 32'h108, 32'h0,        32'h0BADF00D, 5'd11, 1, 1, 0, 7,   7, 8, 32'h0BADF00D, 1, 2'b00};
        tbl[5]  = '{1'b0, 32'h300, 32'h0,        32'h11111111, 5'd3,  1, 1, 0, 100, 7, 8, 32'h0BADF00D, 0, 2'b10};
        tbl[6]  = '{1'b0, 32'h77,  32'h0,        32'h0,        5'd4,  1, 0, 0, 0,   0, 0, 32'h77,       1, 2'b10};
        tbl[7]  = '{1'b1, 32'h102, 32'h0,        32'h0,        5'd6,  1, 1, 0, 0,   0, 0, 32'h0,        0, 2'b01};
        tbl[8]  = '{1'b0, 32'h400, 32'hAAAA5555, 32'h0,        5'd8,  0, 0, 1, 100, 7, 8, 32'h400,      0, 2'b01};
        tbl[9]  = '{1'b0, 32'h401, 32'h0,        32'h0,        5'd2,  0, 0, 1, 0,   0, 0, 32'h401,      0, 2'b01};
        tbl[10] = '{1'b0, 32'h200, 32'h0,        32'h0,        5'd12, 1, 1, 0, 2,   2, 3, 32'h12345678, 1, 2'b01};

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst) do_reset();
            if (tbl[i].mt && tbl[i].rdata != 32'h0) dev_mem[tbl[i].a] = tbl[i].rdata;
            issue(tbl[i].a, tbl[i].wd, tbl[i].wr, tbl[i].rw, tbl[i].mt, tbl[i].mw,
                  tbl[i].waits, st, va);
            chk($sformatf("v%0d_stalls", i), 32'(st), 32'(tbl[i].exp_stalls));
            chk($sformatf("v%0d_valids", i), 32'(va), 32'(tbl[i].exp_valids));
            chk($sformatf("v%0d_resultW", i), resultW, tbl[i].exp_result);
            chk($sformatf("v%0d_writeregW", i), 32'(writeregW), 32'(tbl[i].wr));
            chk($sformatf("v%0d_regwriteW", i), 32'(regwriteW), 32'(tbl[i].exp_rw));
            chk($sformatf("v%0d_errcodeM", i), 32'(errcodeM), 32'(tbl[i].exp_err));
        end

        // Reset in the second wait cycle of a hung load.
        set_e(32'h500, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midwait_stall_before", 32'(stallM), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midwait_valid", 32'(dmem_valid), 32'h0);
        chk("midwait_stallM", 32'(stallM), 32'h0);
        chk("midwait_addr", dmem_addr, 32'h0);
        chk("midwait_aluoutM", aluoutM, 32'h0);
        chk("midwait_resultW", resultW, 32'h0);
        chk("midwait_errcodeM", 32'(errcodeM), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(32'h504, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1, st, va);
        chk("post_rst_stalls", 32'(st), 32'h1);
        chk("post_rst_resultW", resultW, 32'h5A5A0A0B);
        chk("post_rst_regwriteW", 32'(regwriteW), 32'h1);

        // Back-to-back: ALU, zero-wait load, ALU.
        dmem_ready = 1'b1;
        dmem_rdata = 32'h5A5A0F4F;
        set_e(32'h1, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("b2b_aluoutM_0", aluoutM, 32'h1);
        set_e(32'h40, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("b2b_aluoutM_1", aluoutM, 32'h40);
        chk("b2b_resultW_0", resultW, 32'h1);
        #1;
        chk("b2b_valid", 32'(dmem_valid), 32'h1);
        chk("b2b_stallM", 32'(stallM), 32'h0);
        set_e(32'h3, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("b2b_aluoutM_2", aluoutM, 32'h3);
        chk("b2b_resultW_1", resultW, 32'h5A5A0F4F);
        set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("b2b_resultW_2", resultW, 32'h3);
        chk("b2b_writeregW_2", 32'(writeregW), 32'h3);
        dmem_ready = 1'b0;

        // Randomized ops against a spec-level model.
        dev_mem.delete();
        ref_mem.delete();
        for (int i = 0; i < 300; i++) begin
            int          kind, waits, exp_st, exp_va;
            logic [31:0] a, wd, exp_res;
            logic [4:0]  wr;
            logic        rw, mis, abort, xfer, exp_rw;
            if (i % 50 == 0) do_reset();
            kind  = $urandom_range(0, 2);
            a     = 32'($urandom_range(0, 63)) << 2;
            if (kind != 0 && $urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            wd    = $urandom;
            wr    = 5'($urandom_range(0, 31));
            waits = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 3);
            rw    = (kind == 1) ? 1'b1 : (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0;

            mis = (kind != 0) && (a[1:0] != 2'b00);
            abort = 1'b0; xfer = 1'b0; exp_st = 0; exp_va = 0;
            if (kind != 0 && !mis) begin
                if (waits <= T - 1) begin
                    exp_st = waits; exp_va = waits + 1; xfer = 1'b1;
                end else begin
                    exp_st = T - 1; exp_va = T; abort = 1'b1;
                end
            end
            if (xfer && kind == 1) rd_m = ref_rd(a);
            if (xfer && kind == 2) ref_mem[a] = wd;
            if (err_m == 2'b00) err_m = mis ? 2'b01 : abort ? 2'b10 : 2'b00;
            exp_rw  = rw && !mis && !abort;
            exp_res = (kind == 1) ? rd_m : a;

            issue(a, wd, wr, rw, kind == 1, kind == 2, waits, st, va);
            chk("rnd_stalls", 32'(st), 32'(exp_st));
            chk("rnd_valids", 32'(va), 32'(exp_va));
            chk("rnd_resultW", resultW, exp_res);
            chk("rnd_writeregW", 32'(writeregW), 32'(wr));
            chk("rnd_regwriteW", 32'(regwriteW), 32'(exp_rw));
            chk("rnd_errcodeM", 32'(errcodeM), 32'(err_m));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
